// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: flag bit positions, datapath widths and the
// entry format buffered between the ALU and writeback.
package alu_pkg;

   localparam int DATA_W = 8;
   localparam int FLAG_W = 4;
   localparam int RD_W   = 3;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_P = 3;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [FLAG_W-1:0] flags;
      logic [RD_W-1:0]   rd;
      logic              set_flags;
   } ex_entry_t;

endpackage

// File: rtl/ex_skid_fifo.sv
// Two-entry in-order valid/ready buffer of ALU results with synchronous flush.
// Slot 0 is always the head, so the outputs come straight from a register.
module ex_skid_fifo
   import alu_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      flush,
   input  logic      in_valid,
   output logic      in_ready,
   input  ex_entry_t in_entry,
   output logic      out_valid,
   input  logic      out_ready,
   output ex_entry_t out_entry
);

   logic [1:0] count_q, count_d;
   ex_entry_t  slot0_q, slot0_d;
   ex_entry_t  slot1_q, slot1_d;
   logic       push, pop;

   // in_ready looks only at local state and flush, never at out_ready.
   assign in_ready  = (count_q != 2'd2) && !flush;
   assign out_valid = (count_q != 2'd0);
   assign out_entry = out_valid ? slot0_q : '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      count_d = count_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               slot0_d = in_entry;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            case ({push, pop})
               2'b11: slot0_d = in_entry;
               2'b01: count_d = 2'd0;
               2'b10: begin
                  slot1_d = in_entry;
                  count_d = 2'd2;
               end
               default: ;
            endcase
         end
         default: begin
            // Full: no push is possible, a pop shifts the tail into the head.
            if (pop) begin
               slot0_d = slot1_q;
               count_d = 2'd1;
            end
         end
      endcase
      if (flush) begin
         count_d = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 2'd0;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         count_q <= count_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

endmodule

// File: rtl/ex_result_stage.sv
// Result stage between the ALU and writeback: buffers up to two ops and keeps
// the architectural flag register. EX_STICKY_OVF_EN adds a sticky overflow bit.
module ex_result_stage
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [FLAG_W-1:0] in_flags,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_set_flags,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [RD_W-1:0]   out_rd,
   output logic [FLAG_W-1:0] out_flags,
`ifdef EX_STICKY_OVF_EN
   input  logic              clr_sticky,
   output logic              sticky_ovf,
`endif
   output logic [FLAG_W-1:0] flags_q
);

   ex_entry_t         inEntry, headEntry;
   logic              retire;
   logic [FLAG_W-1:0] flags_d;

   assign inEntry = '{result: in_result, flags: in_flags, rd: in_rd, set_flags: in_set_flags};

   ex_skid_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_entry  (inEntry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_entry (headEntry)
   );

   assign out_result = headEntry.result;
   assign out_rd     = headEntry.rd;
   assign out_flags  = headEntry.flags;
   assign retire     = out_valid && out_ready;

   // Flags commit at retire time, so a flush only drops ops that never retired.
   always_comb begin
      flags_d = flags_q;
      if (retire && headEntry.set_flags) begin
         flags_d = headEntry.flags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

`ifdef EX_STICKY_OVF_EN
   logic stickyOvf_q, stickyOvf_d;

   assign sticky_ovf = stickyOvf_q;

   // A new overflow in the same cycle as a clear must not be lost.
   always_comb begin
      stickyOvf_d = stickyOvf_q;
      if (clr_sticky) begin
         stickyOvf_d = 1'b0;
      end
      if (retire && headEntry.set_flags && headEntry.flags[FLAG_V]) begin
         stickyOvf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stickyOvf_q <= 1'b0;
      end else begin
         stickyOvf_q <= stickyOvf_d;
      end
   end
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage with a retire-order scoreboard and a
// reference model of occupancy and flags sampled on the falling clock edge.
module tb_ex_result_stage;

   typedef struct packed {
      logic [7:0] result;
      logic [3:0] flags;
      logic [2:0] rd;
      logic       setFlags;
   } tbEntry_t;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_result;
   logic [3:0] in_flags;
   logic [2:0] in_rd;
   logic       in_set_flags;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_result;
   logic [2:0] out_rd;
   logic [3:0] out_flags;
   logic [3:0] flags_q;
`ifdef EX_STICKY_OVF_EN
   logic       clr_sticky;
   logic       sticky_ovf;
   logic       mSticky;
`endif

   int         total = 0;
   int         bad = 0;
   int         retires = 0;
   int         retireMark;
   tbEntry_t   expQ[$];
   tbEntry_t   head;
   logic [3:0] mFlags;
   logic       expReady;
   logic       expValid;
   logic       doRetire;

   ex_result_stage dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_result    (in_result),
      .in_flags     (in_flags),
      .in_rd        (in_rd),
      .in_set_flags (in_set_flags),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_rd       (out_rd),
      .out_flags    (out_flags),
`ifdef EX_STICKY_OVF_EN
      .clr_sticky   (clr_sticky),
      .sticky_ovf   (sticky_ovf),
`endif
      .flags_q      (flags_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] res, input logic [3:0] fl,
                                input logic [2:0] rd, input logic sf);
      in_valid     = v;
      in_result    = res;
      in_flags     = fl;
      in_rd        = rd;
      in_set_flags = sf;
   endtask

   // Reference model: evaluates the cycle about to be committed at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         mFlags = 4'b0000;
`ifdef EX_STICKY_OVF_EN
         mSticky = 1'b0;
`endif
      end else begin
         expReady = (expQ.size() < 2) && !flush;
         expValid = (expQ.size() != 0);
         checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
         checkOutput("out_valid", {31'd0, out_valid}, {31'd0, expValid});
         checkOutput("flags_q", {28'd0, flags_q}, {28'd0, mFlags});
`ifdef EX_STICKY_OVF_EN
         checkOutput("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, mSticky});
`endif
         doRetire = 1'b0;
         if (expValid) begin
            head = expQ[0];
            checkOutput("out_result", {24'd0, out_result}, {24'd0, head.result});
            checkOutput("out_rd", {29'd0, out_rd}, {29'd0, head.rd});
            checkOutput("out_flags", {28'd0, out_flags}, {28'd0, head.flags});
            if (out_ready) begin
               doRetire = 1'b1;
               void'(expQ.pop_front());
               retires++;
               if (head.setFlags) mFlags = head.flags;
            end
         end
`ifdef EX_STICKY_OVF_EN
         if (clr_sticky) mSticky = 1'b0;
         if (doRetire && head.setFlags && head.flags[2]) mSticky = 1'b1;
`endif
         if (in_valid && expReady) begin
            expQ.push_back('{result: in_result, flags: in_flags, rd: in_rd, setFlags: in_set_flags});
         end
         if (flush) expQ.delete();
      end
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
`ifdef EX_STICKY_OVF_EN
      clr_sticky = 1'b0;
`endif
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      stepCycle();
      stepCycle();
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_result", {24'd0, out_result}, 32'd0);
      checkOutput("rst_out_rd", {29'd0, out_rd}, 32'd0);
      checkOutput("rst_out_flags", {28'd0, out_flags}, 32'd0);
      checkOutput("rst_flags_q", {28'd0, flags_q}, 32'd0);
      rst = 1'b0;

      // Single op: 0x7F + 0x01
      out_ready = 1'b1;
      applyStimulus(1'b1, 8'h80, 4'b1100, 3'd3, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      checkOutput("single_out_valid_n1", {31'd0, out_valid}, 32'd1);
      checkOutput("single_out_result_n1", {24'd0, out_result}, 32'h80);
      stepCycle();
      checkOutput("single_flags_q", {28'd0, flags_q}, 32'b1100);

      // Back-pressure: fill both slots, then drain in order
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'h00, 4'b0011, 3'd1, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 8'h05, 4'b0000, 3'd2, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      checkOutput("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
      stepCycle();
      stepCycle();
      checkOutput("bp_hold_result", {24'd0, out_result}, 32'h00);
      out_ready = 1'b1;
      stepCycle();
      checkOutput("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
      checkOutput("bp_second_head", {24'd0, out_result}, 32'h05);
      stepCycle();
      stepCycle();

      // Streaming: one result per cycle, no bubbles
      retireMark = retires;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 8'(i), 4'(i), 3'(i), 1'b0);
         stepCycle();
         checkOutput("stream_out_valid", {31'd0, out_valid}, 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      stepCycle();
      stepCycle();
      checkOutput("stream_retire_count", 32'(retires - retireMark), 32'd8);

      // set_flags gating
      applyStimulus(1'b1, 8'h0A, 4'b0101, 3'd4, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 8'h0B, 4'b0010, 3'd5, 1'b0);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      stepCycle();
      stepCycle();
      checkOutput("gate_flags_q", {28'd0, flags_q}, 32'b0101);

      // Flush with full buffer and a valid input
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'h11, 4'b0001, 3'd1, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 8'h22, 4'b0001, 3'd2, 1'b1);
      stepCycle();
      applyStimulus(1'b1, 8'h33, 4'b0001, 3'd3, 1'b1);
      flush = 1'b1;
      stepCycle();
      flush = 1'b0;
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_flags_q", {28'd0, flags_q}, 32'b0101);
      stepCycle();

      // A retire in the flush cycle still commits its flags
      applyStimulus(1'b1, 8'h44, 4'b1000, 3'd4, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      out_ready = 1'b1;
      flush     = 1'b1;
      stepCycle();
      flush = 1'b0;
      checkOutput("flush_retire_flags_q", {28'd0, flags_q}, 32'b1000);
      checkOutput("flush_retire_out_valid", {31'd0, out_valid}, 32'd0);

`ifdef EX_STICKY_OVF_EN
      // Sticky overflow: set by a flag-setting retire, held until cleared
      applyStimulus(1'b1, 8'h80, 4'b0100, 3'd6, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      stepCycle();
      checkOutput("sticky_set", {31'd0, sticky_ovf}, 32'd1);
      stepCycle();
      stepCycle();
      checkOutput("sticky_hold", {31'd0, sticky_ovf}, 32'd1);
      clr_sticky = 1'b1;
      stepCycle();
      clr_sticky = 1'b0;
      checkOutput("sticky_clear", {31'd0, sticky_ovf}, 32'd0);
      applyStimulus(1'b1, 8'h81, 4'b0100, 3'd7, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      stepCycle();
`endif

      // rst and flush together with one entry buffered
      out_ready = 1'b0;
      applyStimulus(1'b1, 8'h77, 4'b1111, 3'd7, 1'b1);
      stepCycle();
      applyStimulus(1'b0, 8'h00, 4'h0, 3'd0, 1'b0);
      rst   = 1'b1;
      flush = 1'b1;
      stepCycle();
      checkOutput("rstflush_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstflush_out_result", {24'd0, out_result}, 32'd0);
      checkOutput("rstflush_out_rd", {29'd0, out_rd}, 32'd0);
      checkOutput("rstflush_out_flags", {28'd0, out_flags}, 32'd0);
      checkOutput("rstflush_flags_q", {28'd0, flags_q}, 32'd0);
`ifdef EX_STICKY_OVF_EN
      checkOutput("rstflush_sticky", {31'd0, sticky_ovf}, 32'd0);
`endif
      rst   = 1'b0;
      flush = 1'b0;
      stepCycle();
      stepCycle();

      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
